// File: rtl/excitation_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : excitation_gen_pkg
// Brief   : Shared LPC constants, FSM state type and LFSR step function.
// Revision: 1.0 - initial release
// ============================================================================
package excitation_gen_pkg;

    localparam int          SAMPLE_WIDTH      = 16;
    localparam int          FRAME_LEN_DEFAULT = 160;
    localparam logic [15:0] LFSR_SEED         = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in a right-shifting register taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/excitation_gen_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Brief   : 16-bit Fibonacci noise LFSR, advances one step per enabled cycle.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
    import excitation_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule
`default_nettype wire

// File: rtl/excitation_gen.sv
`default_nettype none
// ============================================================================
// Module  : excitation_gen
// Brief   : LPC excitation source - impulse train (voiced) or LFSR noise
//           (unvoiced), one frame of FRAME_LEN samples per accepted request.
// Revision: 1.0 - initial release
// ============================================================================
module excitation_gen
    import excitation_gen_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_WIDTH,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int PER_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PER_W-1:0]        period,
    input  logic signed [WIDTH-1:0] gain,
    input  logic                    v,
    output logic                    ready,
    output logic signed [WIDTH-1:0] y,
    output logic                    vout,
    output logic                    done
);

    localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    state_t                  state_q,  state_d;
    logic [PER_W-1:0]        period_q, period_d;
    logic [PER_W-1:0]        phase_q,  phase_d;
    logic signed [WIDTH-1:0] gain_q,   gain_d;
    logic signed [WIDTH-1:0] y_q,      y_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic                    vout_q,   vout_d;
    logic                    done_q,   done_d;
    logic                    ready_q,  ready_d;

    logic                    w_emit;
    logic [PER_W-1:0]        w_emit_per;
    logic [PER_W-1:0]        w_emit_phase;
    logic signed [WIDTH-1:0] w_emit_gain;
    logic signed [WIDTH-1:0] w_quarter;
    logic [PER_W:0]          w_phase_inc;
    logic                    w_lfsr_en;
    logic [15:0]             w_lfsr;
    logic [14:0]             w_lfsr_unused;

    assign w_lfsr_unused = w_lfsr[15:1];

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (w_lfsr_en),
        .q   (w_lfsr)
    );

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        gain_d       = gain_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        y_d          = '0;
        vout_d       = 1'b0;
        done_d       = 1'b0;
        w_lfsr_en    = 1'b0;
        w_emit       = 1'b0;
        w_emit_per   = period_q;
        w_emit_gain  = gain_q;
        w_emit_phase = phase_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (v && ready_q) begin
                    period_d    = period;
                    gain_d      = gain;
                    w_emit      = 1'b1;
                    w_emit_per  = period;
                    w_emit_gain = gain;
                    // A shorter new pitch must not inherit an out-of-range phase
                    if ((period != '0) && (phase_q >= period)) begin
                        w_emit_phase = '0;
                    end
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RUN;
                    ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                ready_d = 1'b0;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    w_emit = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        w_quarter   = w_emit_gain >>> 2;
        w_phase_inc = {1'b0, w_emit_phase} + (PER_W + 1)'(1);

        if (w_emit) begin
            vout_d = 1'b1;
            done_d = (cnt_d == LAST_CNT);
            if (w_emit_per == '0) begin
                y_d       = w_lfsr[0] ? w_quarter : -w_quarter;
                w_lfsr_en = 1'b1;
                phase_d   = w_emit_phase;
            end else begin
                y_d     = (w_emit_phase == '0) ? w_emit_gain : '0;
                phase_d = (w_phase_inc >= {1'b0, w_emit_per}) ? '0
                                                              : w_phase_inc[PER_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            gain_q   <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            vout_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            gain_q   <= gain_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            vout_q   <= vout_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready = ready_q;
    assign y     = y_q;
    assign vout  = vout_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_excitation_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_excitation_gen
// Brief   : Self-checking bench for excitation_gen with a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_excitation_gen;

    localparam int FL = 160;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        period = '0;
    logic signed [15:0] gain = '0;
    logic               v = 1'b0;
    logic               ready;
    logic signed [15:0] y;
    logic               vout;
    logic               done;

    int checks = 0;
    int errors = 0;

    excitation_gen #(.WIDTH(16), .FRAME_LEN(FL), .PER_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .gain   (gain),
        .v      (v),
        .ready  (ready),
        .y      (y),
        .vout   (vout),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: on acceptance the whole frame of expected samples is queued;
    // one entry is consumed per emitting cycle, an empty queue means idle.
    int          exp_q[$];
    int          m_phase = 0;
    logic [15:0] m_lfsr  = 16'hACE1;

    task automatic build_frame(input int p, input int g);
        int q4;
        int s;
        logic fb;
        q4 = g >>> 2;
        if (p != 0 && m_phase >= p) m_phase = 0;
        for (int i = 0; i < FL; i++) begin
            if (p == 0) begin
                s  = m_lfsr[0] ? q4 : -q4;
                fb = m_lfsr[16-16] ^ m_lfsr[16-14] ^ m_lfsr[16-13] ^ m_lfsr[16-11];
                m_lfsr = {fb, m_lfsr[15:1]};
            end else begin
                s = (m_phase == 0) ? g : 0;
                m_phase = (m_phase + 1 >= p) ? 0 : m_phase + 1;
            end
            exp_q.push_back(s);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_phase = 0;
            m_lfsr  = 16'hACE1;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (v) begin
            build_frame(int'(period), int'(gain));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("vout",  int'(vout),  int'(exp_q.size() > 0));
            check("ready", int'(ready), int'(exp_q.size() == 0));
            check("done",  int'(done),  int'(exp_q.size() == 1));
            check("y",     int'(y),     (exp_q.size() > 0) ? exp_q[0] : 0);
        end
    end

    int ys[$];
    bit got_done;

    task automatic wait_ready();
        for (int k = 0; k < 400; k++) begin
            if (ready) return;
            @(negedge clk);
        end
        check("wait_ready_timeout", 0, 1);
    endtask

    task automatic start_frame(input int p, input int g);
        wait_ready();
        period = 16'(p);
        gain   = 16'(g);
        v      = 1'b1;
        @(negedge clk);
        v      = 1'b0;
    endtask

    task automatic collect(input int pulse_at, input int stop_at, input bit noisy);
        ys.delete();
        got_done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            v = 1'b0;
            if (vout) begin
                ys.push_back(int'(y));
                if (ys.size() - 1 == pulse_at) begin
                    v = 1'b1; period = 16'd7; gain = 16'sd123;
                end else if (noisy && ys.size() < FL - 10 && $urandom_range(0, 7) == 0) begin
                    v = 1'b1; period = 16'($urandom); gain = 16'($urandom);
                end
            end
            if (done) begin
                got_done = 1'b1;
                v = 1'b0;
                return;
            end
            if (stop_at > 0 && ys.size() >= stop_at) return;
            @(negedge clk);
        end
        check("collect_timeout", 0, 1);
    endtask

    function automatic int count_nonzero();
        int n = 0;
        foreach (ys[i]) if (ys[i] != 0) n++;
        return n;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int p;
        int g;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_vout",  int'(vout),  0);
        check("reset_y",     int'(y),     0);
        check("reset_done",  int'(done),  0);

        // Voiced, period 40
        start_frame(40, 1000);
        collect(-1, 0, 1'b0);
        check("t1_len", ys.size(), 160);
        check("t1_done", int'(got_done), 1);
        check("t1_y0", ys[0], 1000);
        check("t1_y39", ys[39], 0);
        check("t1_y40", ys[40], 1000);
        check("t1_y120", ys[120], 1000);
        check("t1_pulses", count_nonzero(), 4);
        @(negedge clk);
        check("t1_ready_after", int'(ready), 1);

        // Phase carry across frames
        start_frame(50, 1000);
        collect(-1, 0, 1'b0);
        check("t2a_y150", ys[150], 1000);
        check("t2a_pulses", count_nonzero(), 4);
        start_frame(50, 1000);
        collect(-1, 0, 1'b0);
        check("t2b_y0", ys[0], 0);
        check("t2b_y40", ys[40], 1000);
        check("t2b_y140", ys[140], 1000);
        check("t2b_pulses", count_nonzero(), 3);

        // Phase clamp on shorter period
        start_frame(8, 1000);
        collect(-1, 0, 1'b0);
        check("t3_y0", ys[0], 1000);
        check("t3_y7", ys[7], 0);
        check("t3_y8", ys[8], 1000);
        check("t3_pulses", count_nonzero(), 20);

        // Unvoiced noise
        start_frame(0, 4000);
        collect(-1, 0, 1'b0);
        check("t4_len", ys.size(), 160);
        check("t4_y0", ys[0], 1000);
        check("t4_y1", ys[1], -1000);
        check("t4_y2", ys[2], -1000);
        bad = 0;
        foreach (ys[i]) if (ys[i] != 1000 && ys[i] != -1000) bad++;
        check("t4_all_pm1000", bad, 0);

        // v while busy ignored, then v held into the ready-rise cycle
        start_frame(40, 1000);
        collect(20, 0, 1'b0);
        check("t5_len", ys.size(), 160);
        period = 16'd25; gain = -16'sd500; v = 1'b1;
        @(negedge clk);
        check("t5_idle_ready", int'(ready), 1);
        check("t5_idle_vout", int'(vout), 0);
        @(negedge clk);
        v = 1'b0;
        check("t5_b2b_vout", int'(vout), 1);
        collect(-1, 0, 1'b0);
        check("t5_b2b_len", ys.size(), 160);

        // Mid-frame asynchronous reset
        start_frame(30, 700);
        collect(-1, 75, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_vout", int'(vout), 0);
        check("t6_y", int'(y), 0);
        check("t6_done", int'(done), 0);
        check("t6_ready", int'(ready), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        start_frame(40, 1000);
        collect(-1, 0, 1'b0);
        check("t6_y0", ys[0], 1000);
        check("t6_y40", ys[40], 1000);
        check("t6_len", ys.size(), 160);

        // Randomized frames with spurious v pulses during busy
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 1;
                default: p = $urandom_range(2, 200);
            endcase
            g = int'($signed(16'($urandom)));
            if (f == 3) g = -32768;
            start_frame(p, g);
            collect(-1, 0, 1'b1);
            check("rand_len", ys.size(), 160);
            if (p == 1) check("rand_p1_all_gain", count_nonzero(), (g == 0) ? 0 : 160);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
